// File: rtl/vrf_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : vrf_operand_collector
// Description : Collects banked VRF read data into per-VSB-entry operand
//               slots and dispatches fully assembled entries to the VFU issue
//               path over a valid/ready handshake (round-robin selection).
//
// Ports       : clk, rst_n        - core clock, async active-low reset
//               flush             - synchronous kill of all entries
//               alloc_vld/idx/need- allocate an entry with its field mask
//               ent_busy          - registered per-entry allocated flags
//               rd_vld/data/rs_idx/field_idx
//                                 - per-port read data, one-hot entry,
//                                   destination field
//               disp_vld/rdy/idx/need/data
//                                 - dispatch handshake and payload
//               err_sticky        - protocol violation flag (reset-only clear)
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_operand_collector #(
    parameter int VFULEN         = 256,
    parameter int VRF_RPORT_NUM  = 5,
    parameter int VSB_ENT_NUM    = 16,
    parameter int VSB_ENT_ADDR_W = 4,
    parameter int FIELD_NUM      = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        flush,
    input  logic                                        alloc_vld,
    input  logic [VSB_ENT_ADDR_W-1:0]                   alloc_idx,
    input  logic [FIELD_NUM-1:0]                        alloc_need,
    output logic [VSB_ENT_NUM-1:0]                      ent_busy,
    input  logic [VRF_RPORT_NUM-1:0]                    rd_vld,
    input  logic [VRF_RPORT_NUM-1:0][VFULEN-1:0]        rd_data,
    input  logic [VRF_RPORT_NUM-1:0][VSB_ENT_NUM-1:0]   rd_rs_idx,
    input  logic [VRF_RPORT_NUM-1:0][1:0]               rd_field_idx,
    output logic                                        disp_vld,
    input  logic                                        disp_rdy,
    output logic [VSB_ENT_ADDR_W-1:0]                   disp_idx,
    output logic [FIELD_NUM-1:0]                        disp_need,
    output logic [FIELD_NUM-1:0][VFULEN-1:0]            disp_data,
    output logic                                        err_sticky
);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [VSB_ENT_NUM-1:0]               r_busy;
    logic [FIELD_NUM-1:0]                 r_need [VSB_ENT_NUM];
    logic [FIELD_NUM-1:0]                 r_got  [VSB_ENT_NUM];
    logic [FIELD_NUM-1:0][VFULEN-1:0]     r_data [VSB_ENT_NUM];
    logic [VSB_ENT_ADDR_W-1:0]            r_rr_ptr;
    // Holds the presented entry while the VFU stalls, so a newly ready entry
    // earlier in round-robin order cannot steal the slot mid-handshake.
    logic                                 r_lock_vld;
    logic [VSB_ENT_ADDR_W-1:0]            r_lock_idx;
    logic                                 r_err;

    logic [VSB_ENT_NUM-1:0]               w_ready;
    logic [VSB_ENT_NUM-1:0]               w_live;
    logic                                 w_rr_found;
    logic [VSB_ENT_ADDR_W-1:0]            w_rr_idx;
    logic [VSB_ENT_ADDR_W-1:0]            w_cand;
    logic [VSB_ENT_ADDR_W-1:0]            w_sel_idx;
    logic                                 w_fire;
    logic                                 w_alloc_freed;
    logic                                 w_alloc_ok;
    logic                                 w_alloc_err;
    logic [VRF_RPORT_NUM-1:0]             w_onehot;
    logic [VRF_RPORT_NUM-1:0]             w_field_ok;
    logic [VRF_RPORT_NUM-1:0]             w_hit_live;
    logic [VRF_RPORT_NUM-1:0]             w_port_ok;
    logic [VRF_RPORT_NUM-1:0]             w_port_err;
    logic                                 w_dup;
    logic [FIELD_NUM-1:0]                 w_wr_en   [VSB_ENT_NUM];
    logic [FIELD_NUM-1:0][VFULEN-1:0]     w_wr_data [VSB_ENT_NUM];

    // ------------------------------------------------------------------
    // Per-entry readiness and write-target liveness
    // ------------------------------------------------------------------
    generate
        for (genvar e = 0; e < VSB_ENT_NUM; e++) begin : g_entry
            assign w_ready[e] = r_busy[e] & ((r_need[e] & ~r_got[e]) == '0);
            // An entry allocated this cycle may already receive read data.
            assign w_live[e]  = r_busy[e] |
                                (w_alloc_ok & (alloc_idx == VSB_ENT_ADDR_W'(e)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int i = 0; i < VSB_ENT_NUM; i++) begin
            w_cand = VSB_ENT_ADDR_W'((int'(r_rr_ptr) + i) % VSB_ENT_NUM);
            if (!w_rr_found && w_ready[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    assign w_sel_idx = r_lock_vld ? r_lock_idx : w_rr_idx;
    assign disp_vld  = r_lock_vld ? w_ready[r_lock_idx] : w_rr_found;
    assign disp_idx  = w_sel_idx;
    assign disp_need = r_need[w_sel_idx];
    assign w_fire    = disp_vld & disp_rdy;

    generate
        for (genvar f = 0; f < FIELD_NUM; f++) begin : g_disp
            // Fields the uop does not use are presented as zero.
            assign disp_data[f] = r_need[w_sel_idx][f] ? r_data[w_sel_idx][f]
                                                       : '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Allocation: a same-cycle free of the target makes it allocatable
    // ------------------------------------------------------------------
    assign w_alloc_freed = w_fire & (w_sel_idx == alloc_idx);
    assign w_alloc_ok    = alloc_vld & (~r_busy[alloc_idx] | w_alloc_freed);
    assign w_alloc_err   = alloc_vld &   r_busy[alloc_idx] & ~w_alloc_freed;

    // ------------------------------------------------------------------
    // Read-port legality
    // ------------------------------------------------------------------
    generate
        for (genvar p = 0; p < VRF_RPORT_NUM; p++) begin : g_port
            assign w_onehot[p]   = (rd_rs_idx[p] != '0) &&
                                   ((rd_rs_idx[p] & (rd_rs_idx[p] - VSB_ENT_NUM'(1))) == '0);
            assign w_field_ok[p] = (int'(rd_field_idx[p]) < FIELD_NUM);
            assign w_hit_live[p] = |(rd_rs_idx[p] & w_live);
            assign w_port_ok[p]  = rd_vld[p] & w_onehot[p] & w_field_ok[p] & w_hit_live[p];
            assign w_port_err[p] = rd_vld[p] & ~(w_onehot[p] & w_field_ok[p] & w_hit_live[p]);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Capture routing: ports scanned in ascending order so the highest
    // port index wins a collision on the same entry+field.
    // ------------------------------------------------------------------
    always_comb begin
        w_dup = 1'b0;
        for (int e = 0; e < VSB_ENT_NUM; e++) begin
            w_wr_en[e]   = '0;
            w_wr_data[e] = '0;
        end
        for (int p = 0; p < VRF_RPORT_NUM; p++) begin
            for (int e = 0; e < VSB_ENT_NUM; e++) begin
                for (int f = 0; f < FIELD_NUM; f++) begin
                    if (w_port_ok[p] && rd_rs_idx[p][e] &&
                        (rd_field_idx[p] == 2'(f))) begin
                        if (w_wr_en[e][f]) begin
                            w_dup = 1'b1;
                        end
                        w_wr_en[e][f]   = 1'b1;
                        w_wr_data[e][f] = rd_data[p];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_rr_ptr   <= '0;
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
            for (int e = 0; e < VSB_ENT_NUM; e++) begin
                r_need[e] <= '0;
                r_got[e]  <= '0;
                r_data[e] <= '0;
            end
        end else begin
            r_err <= r_err | w_alloc_err | (|w_port_err) | w_dup;
            if (flush) begin
                // Pointer is kept; any handshake this cycle is discarded.
                r_busy     <= '0;
                r_lock_vld <= 1'b0;
                for (int e = 0; e < VSB_ENT_NUM; e++) begin
                    r_got[e] <= '0;
                end
            end else begin
                if (w_fire) begin
                    r_rr_ptr   <= VSB_ENT_ADDR_W'((int'(w_sel_idx) + 1) % VSB_ENT_NUM);
                    r_lock_vld <= 1'b0;
                end else if (disp_vld) begin
                    r_lock_vld <= 1'b1;
                    r_lock_idx <= w_sel_idx;
                end else begin
                    r_lock_vld <= 1'b0;
                end
                for (int e = 0; e < VSB_ENT_NUM; e++) begin
                    if (w_alloc_ok && (alloc_idx == VSB_ENT_ADDR_W'(e))) begin
                        r_busy[e] <= 1'b1;
                        r_need[e] <= alloc_need;
                        r_got[e]  <= w_wr_en[e];
                    end else if (w_fire && (w_sel_idx == VSB_ENT_ADDR_W'(e))) begin
                        r_busy[e] <= 1'b0;
                        r_got[e]  <= '0;
                    end else begin
                        r_got[e]  <= r_got[e] | w_wr_en[e];
                    end
                    for (int f = 0; f < FIELD_NUM; f++) begin
                        if (w_wr_en[e][f]) begin
                            r_data[e][f] <= w_wr_data[e][f];
                        end
                    end
                end
            end
        end
    end

    assign ent_busy   = r_busy;
    assign err_sticky = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vrf_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_operand_collector
// Description : Directed, table-driven bench for vrf_operand_collector plus
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_operand_collector;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic                 alloc_vld;
    logic [3:0]           alloc_idx;
    logic [2:0]           alloc_need;
    logic [15:0]          ent_busy;
    logic [4:0]           rd_vld;
    logic [4:0][255:0]    rd_data;
    logic [4:0][15:0]     rd_rs_idx;
    logic [4:0][1:0]      rd_field_idx;
    logic                 disp_vld;
    logic                 disp_rdy;
    logic [3:0]           disp_idx;
    logic [2:0]           disp_need;
    logic [2:0][255:0]    disp_data;
    logic                 err_sticky;

    int checks = 0;
    int errors = 0;

    vrf_operand_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .alloc_vld    (alloc_vld),
        .alloc_idx    (alloc_idx),
        .alloc_need   (alloc_need),
        .ent_busy     (ent_busy),
        .rd_vld       (rd_vld),
        .rd_data      (rd_data),
        .rd_rs_idx    (rd_rs_idx),
        .rd_field_idx (rd_field_idx),
        .disp_vld     (disp_vld),
        .disp_rdy     (disp_rdy),
        .disp_idx     (disp_idx),
        .disp_need    (disp_need),
        .disp_data    (disp_data),
        .err_sticky   (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a_vld;
        logic [3:0] a_idx;
        logic [2:0] a_need;
        logic       rd_en;
        int         rd_port;
        int         rd_ent;
        int         rd_field;
        logic [7:0] rd_byte;
        logic       rdy;
        logic       e_vld;
        logic [3:0] e_idx;
        logic [15:0] e_busy;
        logic       e_err;
        logic       e_dchk;
        logic [7:0] e_d0;
        logic [7:0] e_d1;
        logic [7:0] e_d2;
    } vec_t;

    vec_t tv [12];

    function automatic logic [255:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2);
        chk({nm, "_d0"}, disp_data[0], pat(d0));
        chk({nm, "_d1"}, disp_data[1], pat(d1));
        chk({nm, "_d2"}, disp_data[2], pat(d2));
    endtask

    task automatic clear_in();
        flush        = 1'b0;
        alloc_vld    = 1'b0;
        alloc_idx    = '0;
        alloc_need   = '0;
        rd_vld       = '0;
        rd_data      = '0;
        rd_rs_idx    = '0;
        rd_field_idx = '0;
        disp_rdy     = 1'b0;
    endtask

    task automatic set_rd(input int p, input int e, input int f, input logic [7:0] b);
        rd_vld[p]       = 1'b1;
        rd_rs_idx[p]    = 16'h1 << e;
        rd_field_idx[p] = 2'(f);
        rd_data[p]      = pat(b);
    endtask

    task automatic set_alloc(input logic [3:0] idx, input logic [2:0] need);
        alloc_vld  = 1'b1;
        alloc_idx  = idx;
        alloc_need = need;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ord [4];
        logic [7:0] obyte [4];

        //            alloc          rd port/ent/field/byte  rdy  exp vld/idx/busy/err  dchk d0 d1 d2
        tv[0]  = '{1, 4'd3, 3'b011,  0, 0, 0, 0, 8'h00,  0,  0, 4'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[1]  = '{0, 4'd0, 3'b000,  1, 0, 3, 0, 8'hA5,  0,  0, 4'd0, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[2]  = '{0, 4'd0, 3'b000,  0, 0, 0, 0, 8'h00,  0,  0, 4'd0, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[3]  = '{0, 4'd0, 3'b000,  1, 4, 3, 1, 8'h5A,  0,  0, 4'd0, 16'h0008, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[4]  = '{0, 4'd0, 3'b000,  0, 0, 0, 0, 8'h00,  1,  1, 4'd3, 16'h0008, 0,  1, 8'hA5, 8'h5A, 8'h00};
        tv[5]  = '{1, 4'd6, 3'b001,  0, 0, 0, 0, 8'h00,  0,  0, 4'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[6]  = '{0, 4'd0, 3'b000,  1, 2, 6, 0, 8'h11,  0,  0, 4'd0, 16'h0040, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[7]  = '{1, 4'd6, 3'b100,  0, 0, 0, 0, 8'h00,  1,  1, 4'd6, 16'h0040, 0,  1, 8'h11, 8'h00, 8'h00};
        tv[8]  = '{0, 4'd0, 3'b000,  0, 0, 0, 0, 8'h00,  0,  0, 4'd0, 16'h0040, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[9]  = '{0, 4'd0, 3'b000,  1, 1, 6, 2, 8'h33,  0,  0, 4'd0, 16'h0040, 0,  0, 8'h00, 8'h00, 8'h00};
        tv[10] = '{0, 4'd0, 3'b000,  0, 0, 0, 0, 8'h00,  1,  1, 4'd6, 16'h0040, 0,  1, 8'h00, 8'h00, 8'h33};
        tv[11] = '{0, 4'd0, 3'b000,  0, 0, 0, 0, 8'h00,  0,  0, 4'd0, 16'h0000, 0,  0, 8'h00, 8'h00, 8'h00};

        clear_in();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_vld",  disp_vld,   0);
        chk("rst_busy", ent_busy,   0);
        chk("rst_err",  err_sticky, 0);

        // Table: basic assembly / latency and same-cycle free+realloc
        for (int i = 0; i < 12; i++) begin
            clear_in();
            if (tv[i].a_vld) set_alloc(tv[i].a_idx, tv[i].a_need);
            if (tv[i].rd_en) set_rd(tv[i].rd_port, tv[i].rd_ent, tv[i].rd_field, tv[i].rd_byte);
            disp_rdy = tv[i].rdy;
            chk($sformatf("v%0d_vld", i),  disp_vld,   tv[i].e_vld);
            chk($sformatf("v%0d_busy", i), ent_busy,   tv[i].e_busy);
            chk($sformatf("v%0d_err", i),  err_sticky, tv[i].e_err);
            if (tv[i].e_vld) chk($sformatf("v%0d_idx", i), disp_idx, tv[i].e_idx);
            if (tv[i].e_dchk) chk_data($sformatf("v%0d", i), tv[i].e_d0, tv[i].e_d1, tv[i].e_d2);
            tick();
        end

        // Round-robin order, stall stability, lock against a new earlier entry
        do_reset();
        set_alloc(4'd2, 3'b001); tick();
        set_alloc(4'd5, 3'b001); tick();
        set_alloc(4'd9, 3'b001); tick();
        clear_in();
        set_rd(0, 2, 0, 8'h22);
        set_rd(1, 5, 0, 8'h55);
        set_rd(2, 9, 0, 8'h99);
        tick();
        clear_in();
        for (int k = 0; k < 4; k++) begin
            clear_in();
            if (k == 1) set_alloc(4'd1, 3'b000);
            chk($sformatf("stall%0d_vld", k),  disp_vld,  1);
            chk($sformatf("stall%0d_idx", k),  disp_idx,  4'd2);
            chk($sformatf("stall%0d_need", k), disp_need, 3'b001);
            chk_data($sformatf("stall%0d", k), 8'h22, 8'h00, 8'h00);
            tick();
        end
        ord   = '{4'd2, 4'd5, 4'd9, 4'd1};
        obyte = '{8'h22, 8'h55, 8'h99, 8'h00};
        for (int k = 0; k < 4; k++) begin
            clear_in();
            disp_rdy = 1'b1;
            chk($sformatf("rr%0d_vld", k), disp_vld, 1);
            chk($sformatf("rr%0d_idx", k), disp_idx, ord[k]);
            chk($sformatf("rr%0d_d0", k),  disp_data[0], pat(obyte[k]));
            tick();
        end
        clear_in();
        chk("rr_end_vld",  disp_vld, 0);
        chk("rr_end_busy", ent_busy, 0);

        // Five ports in one cycle with a duplicate on entry0 field0 (RR ptr = 2)
        set_alloc(4'd0, 3'b111); tick();
        set_alloc(4'd1, 3'b111); tick();
        clear_in();
        set_rd(0, 0, 1, 8'hB1);
        set_rd(1, 0, 0, 8'h11);
        set_rd(2, 0, 2, 8'hB2);
        set_rd(3, 0, 0, 8'h33);
        set_rd(4, 1, 0, 8'hC0);
        chk("dup_err_before", err_sticky, 0);
        tick();
        clear_in();
        chk("dup_err_after", err_sticky, 1);
        chk("dup_busy",      ent_busy,   16'h0003);
        chk("dup_vld",       disp_vld,   1);
        chk("dup_idx",       disp_idx,   4'd0);
        chk_data("dup", 8'h33, 8'hB1, 8'hB2);
        set_rd(0, 1, 1, 8'hC1);
        set_rd(1, 1, 2, 8'hC2);
        disp_rdy = 1'b1;
        tick();
        clear_in();
        disp_rdy = 1'b1;
        chk("e1_vld", disp_vld, 1);
        chk("e1_idx", disp_idx, 4'd1);
        chk_data("e1", 8'hC0, 8'hC1, 8'hC2);
        tick();
        clear_in();
        chk("e1_done_busy", ent_busy, 0);
        chk("e1_done_vld",  disp_vld, 0);

        // Read to unallocated entry
        do_reset();
        set_rd(0, 7, 0, 8'h77);
        tick();
        clear_in();
        chk("unalloc_err",  err_sticky, 1);
        chk("unalloc_busy", ent_busy,   0);
        chk("unalloc_vld",  disp_vld,   0);

        // Alloc to a busy entry is ignored
        do_reset();
        set_alloc(4'd4, 3'b001); tick();
        set_alloc(4'd4, 3'b010); tick();
        clear_in();
        chk("realloc_err",  err_sticky, 1);
        chk("realloc_busy", ent_busy,   16'h0010);
        set_rd(0, 4, 0, 8'h44);
        tick();
        clear_in();
        chk("realloc_vld",  disp_vld,  1);
        chk("realloc_idx",  disp_idx,  4'd4);
        chk("realloc_need", disp_need, 3'b001);
        chk("realloc_d0",   disp_data[0], pat(8'h44));

        // Non-one-hot destination is dropped
        do_reset();
        set_alloc(4'd4, 3'b001); tick();
        clear_in();
        rd_vld[0]       = 1'b1;
        rd_rs_idx[0]    = 16'h0030;
        rd_field_idx[0] = 2'd0;
        rd_data[0]      = pat(8'hEE);
        tick();
        clear_in();
        chk("onehot_err", err_sticky, 1);
        chk("onehot_vld", disp_vld,   0);

        // Illegal field index is dropped
        do_reset();
        set_alloc(4'd4, 3'b001); tick();
        clear_in();
        set_rd(0, 4, 3, 8'hEE);
        tick();
        clear_in();
        chk("field3_err", err_sticky, 1);
        chk("field3_vld", disp_vld,   0);

        // Flush with partially filled entries, overriding alloc and capture
        do_reset();
        set_alloc(4'd1, 3'b111); tick();
        clear_in();
        set_alloc(4'd2, 3'b111);
        set_rd(0, 1, 0, 8'h01);
        tick();
        clear_in();
        set_alloc(4'd3, 3'b111);
        set_rd(1, 2, 1, 8'h02);
        tick();
        clear_in();
        chk("preflush_busy", ent_busy, 16'h000E);
        chk("preflush_vld",  disp_vld, 0);
        flush = 1'b1;
        set_alloc(4'd8, 3'b000);
        set_rd(0, 3, 0, 8'h03);
        tick();
        clear_in();
        chk("flush_busy", ent_busy,   0);
        chk("flush_vld",  disp_vld,   0);
        chk("flush_err",  err_sticky, 0);

        // Asynchronous reset in the middle of a cycle
        set_alloc(4'd5, 3'b000); tick();
        clear_in();
        set_rd(0, 7, 0, 8'h07);
        tick();
        clear_in();
        chk("prerst_vld", disp_vld,   1);
        chk("prerst_idx", disp_idx,   4'd5);
        chk("prerst_err", err_sticky, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",  disp_vld,   0);
        chk("arst_busy", ent_busy,   0);
        chk("arst_err",  err_sticky, 0);
        chk("arst_idx",  disp_idx,   0);
        chk("arst_need", disp_need,  0);
        chk_data("arst", 8'h00, 8'h00, 8'h00);
        #10;
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
